// File: rtl/pong_pkg.sv
// pong_pkg: constants, types and FSM encoding shared by the collision stage.
//   - Default screen, ball and paddle geometry (the top module exposes them as parameters).
//   - coord_t: 10-bit unsigned coordinate, wide enough that ball + size never wraps.
//   - cd_state_t: collision FSM states PLAY / X_HOLD / SCORED.
package pong_pkg;

  localparam int SCREEN_WIDTH    = 240;
  localparam int SCREEN_HEIGHT   = 320;
  localparam int BALL_SIZE       = 5;
  localparam int PADDLE_WIDTH    = 5;
  localparam int PADDLE_HEIGHT   = 40;
  localparam int LEFT_PADDLE_X   = 5;
  localparam int RIGHT_PADDLE_X  = 230;
  localparam int COOLDOWN_CYCLES = 8;
  localparam int SERVE_HOLD      = 4;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    X_HOLD = 2'd1,
    SCORED = 2'd2
  } cd_state_t;

endpackage

// File: rtl/paddle_hit_check.sv
// paddle_hit_check: combinational ball/paddle rectangle-overlap test.
//   Parameters : PADDLE_X (paddle left edge), RIGHT_SIDE (selects the X-overlap form),
//                BALL_SIZE, PADDLE_WIDTH, PADDLE_HEIGHT.
//   Ports      : ball_x_i, ball_y_i - ball top-left corner (10-bit, zero-extended)
//                paddle_y_i         - paddle top edge (10-bit, zero-extended)
//                hit_o              - ball overlaps the paddle rectangle
// Direction qualification is done by the caller.
module paddle_hit_check
  import pong_pkg::*;
#(
  parameter int PADDLE_X      = LEFT_PADDLE_X,
  parameter bit RIGHT_SIDE    = 1'b0,
  parameter int BALL_SIZE     = pong_pkg::BALL_SIZE,
  parameter int PADDLE_WIDTH  = pong_pkg::PADDLE_WIDTH,
  parameter int PADDLE_HEIGHT = pong_pkg::PADDLE_HEIGHT
) (
  input  coord_t ball_x_i,
  input  coord_t ball_y_i,
  input  coord_t paddle_y_i,
  output logic   hit_o
);

  localparam coord_t BS   = coord_t'(BALL_SIZE);
  localparam coord_t PX   = coord_t'(PADDLE_X);
  localparam coord_t PXW  = coord_t'(PADDLE_X + PADDLE_WIDTH);
  localparam coord_t PH   = coord_t'(PADDLE_HEIGHT);

  logic x_overlap;
  logic y_overlap;

  // The right paddle is approached from the left, so its near face is PADDLE_X
  // (inclusive); the left paddle is approached from the right and its near face
  // PADDLE_X+PADDLE_WIDTH is inclusive instead.
  generate
    if (RIGHT_SIDE) begin : g_right
      assign x_overlap = ((ball_x_i + BS) >= PX) && (ball_x_i < PXW);
    end else begin : g_left
      assign x_overlap = (ball_x_i <= PXW) && ((ball_x_i + BS) > PX);
    end
  endgenerate

  assign y_overlap = ((ball_y_i + BS) > paddle_y_i) && (ball_y_i < (paddle_y_i + PH));
  assign hit_o     = x_overlap && y_overlap;

endmodule

// File: rtl/ball_collision_detect.sv
// ball_collision_detect: wall/paddle collision and scoring stage ahead of the ball mover.
//   Inputs : clock, reset (sync, active-high), ballXValue[7:0], ballYValue[8:0],
//            direction (1 = moving right), leftPaddleY[8:0], rightPaddleY[8:0]
//   Outputs: changeXDirection, changeYDirection, pointLeft, pointRight (1-cycle pulses),
//            serveRequest (level, SERVE_HOLD cycles), rallyCount[7:0]
//   All outputs are registered: events sampled at edge k appear in cycle k+1.
//   Build option: define PONG_RALLY_COUNT_EN to implement the rally counter;
//   otherwise rallyCount is tied to zero and no counter register exists.
module ball_collision_detect
  import pong_pkg::*;
#(
  parameter int SCREEN_WIDTH    = pong_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT   = pong_pkg::SCREEN_HEIGHT,
  parameter int BALL_SIZE       = pong_pkg::BALL_SIZE,
  parameter int PADDLE_WIDTH    = pong_pkg::PADDLE_WIDTH,
  parameter int PADDLE_HEIGHT   = pong_pkg::PADDLE_HEIGHT,
  parameter int LEFT_PADDLE_X   = pong_pkg::LEFT_PADDLE_X,
  parameter int RIGHT_PADDLE_X  = pong_pkg::RIGHT_PADDLE_X,
  parameter int COOLDOWN_CYCLES = pong_pkg::COOLDOWN_CYCLES,
  parameter int SERVE_HOLD      = pong_pkg::SERVE_HOLD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ballXValue,
  input  logic [8:0] ballYValue,
  input  logic       direction,
  input  logic [8:0] leftPaddleY,
  input  logic [8:0] rightPaddleY,
  output logic       changeXDirection,
  output logic       changeYDirection,
  output logic       pointLeft,
  output logic       pointRight,
  output logic       serveRequest,
  output logic [7:0] rallyCount
);

  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
  localparam int SW = $clog2(SERVE_HOLD + 1);

  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_CYCLES);
  localparam logic [CW-1:0] COOL_ONE  = CW'(1);
  localparam logic [SW-1:0] SERVE_LOAD = SW'(SERVE_HOLD);
  localparam logic [SW-1:0] SERVE_ONE  = SW'(1);

  localparam coord_t RIGHT_LIMIT  = coord_t'(SCREEN_WIDTH - BALL_SIZE);
  localparam coord_t BOTTOM_LIMIT = coord_t'(SCREEN_HEIGHT - BALL_SIZE);

  coord_t ball_x;
  coord_t ball_y;
  coord_t left_py;
  coord_t right_py;

  assign ball_x   = {2'b00, ballXValue};
  assign ball_y   = {1'b0, ballYValue};
  assign left_py  = {1'b0, leftPaddleY};
  assign right_py = {1'b0, rightPaddleY};

  logic left_overlap;
  logic right_overlap;

  paddle_hit_check #(
    .PADDLE_X      (LEFT_PADDLE_X),
    .RIGHT_SIDE    (1'b0),
    .BALL_SIZE     (BALL_SIZE),
    .PADDLE_WIDTH  (PADDLE_WIDTH),
    .PADDLE_HEIGHT (PADDLE_HEIGHT)
  ) u_left_check (
    .ball_x_i   (ball_x),
    .ball_y_i   (ball_y),
    .paddle_y_i (left_py),
    .hit_o      (left_overlap)
  );

  paddle_hit_check #(
    .PADDLE_X      (RIGHT_PADDLE_X),
    .RIGHT_SIDE    (1'b1),
    .BALL_SIZE     (BALL_SIZE),
    .PADDLE_WIDTH  (PADDLE_WIDTH),
    .PADDLE_HEIGHT (PADDLE_HEIGHT)
  ) u_right_check (
    .ball_x_i   (ball_x),
    .ball_y_i   (ball_y),
    .paddle_y_i (right_py),
    .hit_o      (right_overlap)
  );

  // Event decode. A miss is only declared when the paddle on that side did not
  // catch the ball, which gives hits priority over misses.
  logic right_hit;
  logic left_hit;
  logic paddle_hit;
  logic right_miss;
  logic left_miss;
  logic any_miss;
  logic wall_hit;

  assign right_hit  = direction && right_overlap;
  assign left_hit   = !direction && left_overlap;
  assign paddle_hit = right_hit || left_hit;
  assign right_miss = direction && (ball_x >= RIGHT_LIMIT) && !right_hit;
  assign left_miss  = !direction && (ball_x == '0) && !left_hit;
  assign any_miss   = right_miss || left_miss;
  assign wall_hit   = (ball_y == '0) || (ball_y >= BOTTOM_LIMIT);

  cd_state_t     state_q;
  logic [CW-1:0] x_cnt_q;
  logic [CW-1:0] y_cnt_q;
  logic [SW-1:0] s_cnt_q;

  // X/scoring FSM plus the Y cooldown; every output is a register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= PLAY;
      x_cnt_q          <= '0;
      y_cnt_q          <= '0;
      s_cnt_q          <= '0;
      changeXDirection <= 1'b0;
      changeYDirection <= 1'b0;
      pointLeft        <= 1'b0;
      pointRight       <= 1'b0;
      serveRequest     <= 1'b0;
    end else begin
      changeXDirection <= 1'b0;
      changeYDirection <= 1'b0;
      pointLeft        <= 1'b0;
      pointRight       <= 1'b0;

      case (state_q)
        PLAY: begin
          if (paddle_hit) begin
            changeXDirection <= 1'b1;
            x_cnt_q          <= COOL_LOAD;
            state_q          <= X_HOLD;
          end else if (any_miss) begin
            // Right miss means the left player scored, and vice versa.
            pointLeft    <= right_miss;
            pointRight   <= left_miss;
            s_cnt_q      <= SERVE_LOAD;
            serveRequest <= 1'b1;
            state_q      <= SCORED;
          end
        end
        X_HOLD: begin
          if (x_cnt_q == COOL_ONE) begin
            x_cnt_q <= '0;
            state_q <= PLAY;
          end else begin
            x_cnt_q <= x_cnt_q - COOL_ONE;
          end
        end
        SCORED: begin
          if (s_cnt_q == SERVE_ONE) begin
            s_cnt_q      <= '0;
            serveRequest <= 1'b0;
            state_q      <= PLAY;
          end else begin
            s_cnt_q <= s_cnt_q - SERVE_ONE;
          end
        end
        default: begin
          state_q <= PLAY;
        end
      endcase

      // Y cooldown keeps running during SCORED; only the pulse is suppressed.
      if (y_cnt_q != '0) begin
        y_cnt_q <= y_cnt_q - COOL_ONE;
      end
      if ((state_q != SCORED) && wall_hit && (y_cnt_q == '0)) begin
        changeYDirection <= 1'b1;
        y_cnt_q          <= COOL_LOAD;
      end
    end
  end

`ifdef PONG_RALLY_COUNT_EN
  logic [7:0] rally_q;
  logic [7:0] rally_d;

  // Counts only the events the FSM actually acts on (PLAY state).
  always_comb begin
    rally_d = rally_q;
    if (state_q == PLAY) begin
      if (paddle_hit) begin
        if (rally_q != 8'hFF) begin
          rally_d = rally_q + 8'd1;
        end
      end else if (any_miss) begin
        rally_d = 8'd0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rally_q <= 8'd0;
    end else begin
      rally_q <= rally_d;
    end
  end

  assign rallyCount = rally_q;
`else
  assign rallyCount = 8'd0;
`endif

endmodule

// File: tb/tb_ball_collision_detect.sv
// tb_ball_collision_detect: directed scenarios with literal expectations followed by
// randomized stimulus; a timestamp-based reference model predicts every output.
module tb_ball_collision_detect;

  localparam int W   = 240;
  localparam int H   = 320;
  localparam int BS  = 5;
  localparam int PW  = 5;
  localparam int PH  = 40;
  localparam int LPX = 5;
  localparam int RPX = 230;
  localparam int CD  = 8;
  localparam int SH  = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] ballXValue;
  logic [8:0] ballYValue;
  logic       direction;
  logic [8:0] leftPaddleY;
  logic [8:0] rightPaddleY;
  logic       changeXDirection;
  logic       changeYDirection;
  logic       pointLeft;
  logic       pointRight;
  logic       serveRequest;
  logic [7:0] rallyCount;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ball_collision_detect dut (
    .clock            (clock),
    .reset            (reset),
    .ballXValue       (ballXValue),
    .ballYValue       (ballYValue),
    .direction        (direction),
    .leftPaddleY      (leftPaddleY),
    .rightPaddleY     (rightPaddleY),
    .changeXDirection (changeXDirection),
    .changeYDirection (changeYDirection),
    .pointLeft        (pointLeft),
    .pointRight       (pointRight),
    .serveRequest     (serveRequest),
    .rallyCount       (rallyCount)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int rally_exp(input int v);
`ifdef PONG_RALLY_COUNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // ---------------- reference model ----------------
  // Tracks, in edge indices, when X, Y and play become available again.
  longint n = 0;
  longint x_res = 0, y_res = 0, p_res = 0;
  int m_rally = 0;
  int e_x = 0, e_y = 0, e_pl = 0, e_pr = 0, e_s = 0;
  bit have_exp = 0;

  initial begin
    forever begin
      @(negedge clock);
      if (have_exp) begin
        check("mon_changeX", changeXDirection, e_x);
        check("mon_changeY", changeYDirection, e_y);
        check("mon_pointLeft", pointLeft, e_pl);
        check("mon_pointRight", pointRight, e_pr);
        check("mon_serve", serveRequest, e_s);
        check("mon_rally", rallyCount, rally_exp(m_rally));
      end
      // Inputs now stable until the coming edge n; predict its outcome.
      begin
        int bx, by, lpy, rpy;
        bit rh, lh, rm, lm, wall, scored;
        bx = int'(ballXValue); by = int'(ballYValue);
        lpy = int'(leftPaddleY); rpy = int'(rightPaddleY);
        if (reset) begin
          e_x = 0; e_y = 0; e_pl = 0; e_pr = 0; e_s = 0; m_rally = 0;
          x_res = n + 1; y_res = n + 1; p_res = n + 1;
        end else begin
          rh = direction && (bx + BS >= RPX) && (bx < RPX + PW) && (by + BS > rpy) && (by < rpy + PH);
          lh = !direction && (bx <= LPX + PW) && (bx + BS > LPX) && (by + BS > lpy) && (by < lpy + PH);
          rm = direction && (bx >= W - BS) && !rh;
          lm = !direction && (bx == 0) && !lh;
          wall = (by == 0) || (by >= H - BS);
          scored = (n < p_res);
          e_x = 0; e_y = 0; e_pl = 0; e_pr = 0;
          if (!scored) begin
            if (n >= x_res) begin
              if (rh || lh) begin
                e_x = 1;
                if (m_rally < 255) m_rally++;
                x_res = n + CD + 1;
              end else if (rm || lm) begin
                e_pl = int'(rm); e_pr = int'(lm);
                m_rally = 0;
                p_res = n + SH + 1;
              end
            end
            if (wall && n >= y_res) begin
              e_y = 1;
              y_res = n + CD + 1;
            end
          end
          e_s = (n < p_res - 1) ? 1 : 0;
        end
      end
      have_exp = 1;
      n++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ball(input int x, input int y, input bit d);
    ballXValue = 8'(x); ballYValue = 9'(y); direction = d;
  endtask

  initial begin
    int xs[16];
    int ys[8];
    int hold;
    xs = '{0, 1, 2, 5, 8, 10, 11, 120, 224, 225, 226, 230, 234, 235, 236, 239};
    ys = '{0, 1, 20, 100, 160, 314, 315, 319};

    reset = 1'b1;
    set_ball(120, 160, 1'b0);
    leftPaddleY = 9'd100; rightPaddleY = 9'd100;

    // Reset for two cycles: everything zero.
    tick(); tick();
    check("rst_changeX", changeXDirection, 0);
    check("rst_changeY", changeYDirection, 0);
    check("rst_pointLeft", pointLeft, 0);
    check("rst_pointRight", pointRight, 0);
    check("rst_serve", serveRequest, 0);
    check("rst_rally", rallyCount, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_pulses", int'(changeXDirection | changeYDirection | pointLeft | pointRight), 0);
    end

    // Right paddle hit, then cooldown with the same inputs.
    set_ball(226, 100, 1'b1); rightPaddleY = 9'd90;
    tick();
    check("rhit_changeX", changeXDirection, 1);
    check("rhit_rally", rallyCount, rally_exp(1));
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rhit_cooldown", changeXDirection, 0);
    end

    // Right miss: point to left, serve for 4 cycles.
    set_ball(236, 20, 1'b1); rightPaddleY = 9'd200;
    tick();
    check("rmiss_pointLeft", pointLeft, 1);
    check("rmiss_pointRight", pointRight, 0);
    check("rmiss_rally", rallyCount, 0);
    check("rmiss_serve0", serveRequest, 1);
    set_ball(120, 160, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rmiss_serve", serveRequest, 1);
      check("rmiss_single", pointLeft, 0);
    end
    tick();
    check("rmiss_serve_end", serveRequest, 0);

    // Top wall held: pulse every 9 cycles.
    set_ball(120, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("wall_period", changeYDirection, (i % 9 == 0) ? 1 : 0);
    end
    set_ball(120, 160, 1'b0);
    repeat (10) tick();

    // Left paddle hit in the corner together with a wall hit.
    set_ball(2, 0, 1'b0); leftPaddleY = 9'd0;
    tick();
    check("corner_changeX", changeXDirection, 1);
    check("corner_changeY", changeYDirection, 1);
    check("corner_rally", rallyCount, rally_exp(1));
    set_ball(120, 160, 1'b0);
    repeat (10) tick();

    // Reset during the second SCORED cycle.
    set_ball(236, 20, 1'b1); rightPaddleY = 9'd200;
    tick();
    check("scr_pointLeft", pointLeft, 1);
    set_ball(120, 160, 1'b0);
    tick();
    check("scr_serve", serveRequest, 1);
    reset = 1'b1;
    tick();
    check("scr_rst_serve", serveRequest, 0);
    check("scr_rst_rally", rallyCount, 0);
    reset = 1'b0;
    set_ball(226, 100, 1'b1); rightPaddleY = 9'd90;
    tick();
    check("scr_rst_play_hit", changeXDirection, 1);
    check("scr_rst_play_rally", rallyCount, rally_exp(1));
    set_ball(120, 160, 1'b0);
    repeat (10) tick();

    // Randomized play.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        int by;
        if ($urandom_range(0, 3) == 0) by = $urandom_range(0, 319);
        else by = ys[$urandom_range(0, 7)];
        set_ball(xs[$urandom_range(0, 15)], by, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 0) begin
          leftPaddleY  = 9'($urandom_range(0, 280));
          rightPaddleY = 9'($urandom_range(0, 280));
        end else begin
          leftPaddleY  = 9'((by > 20) ? by - int'($urandom_range(0, 20)) : 0);
          rightPaddleY = 9'((by > 42) ? by - int'($urandom_range(0, 42)) : by);
        end
        hold = $urandom_range(1, 6);
      end
      reset = ($urandom_range(0, 199) == 0);
      tick();
      hold--;
    end
    reset = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
